// File: rtl/fifo_push_packer.sv
// fifo_push_packer: packs IW-bit ready/valid beats into W-bit words and
// pushes them into the write side of an async FIFO. Beats fill lanes
// little-endian (first beat in bits [IW-1:0]). A beat with in_last closes
// the word early, and the unused upper lanes are zero. A single holding
// register decouples the accumulator from the FIFO. push is never asserted
// while full_r is high.
//
// Handshake: a beat transfers on a rising clk edge when in_vld & in_rdy.
// in_rdy depends only on internal state and full_r, and never on in_vld,
// in_data or in_last. push is a one-cycle strobe qualified by ~full_r.
module fifo_push_packer #(
    parameter int W  = 32,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [IW-1:0] in_data,
    input  logic          in_last,
    output logic          in_rdy,
    input  logic          full_r,
    output logic          push,
    output logic [W-1:0]  push_data,
    output logic          busy
);

    localparam int R  = W / IW;
    localparam int CW = (R > 1) ? $clog2(R) : 1;

    generate
        if ((W % IW) != 0 || (W / IW) < 2) begin : g_param_check
            $error("fifo_push_packer: W must be a multiple of IW with W/IW >= 2");
        end
    endgenerate

    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_hold;
    logic          r_hold_vld;

    logic          w_push;
    logic          w_in_rdy;
    logic          w_accept;
    logic          w_complete;
    logic [W-1:0]  w_merged;

    assign w_push     = r_hold_vld & ~full_r;
    assign w_in_rdy   = ~r_hold_vld | w_push;
    assign w_accept   = in_vld & w_in_rdy;
    assign w_complete = w_accept & ((r_cnt == CW'(R - 1)) | in_last);

    // Accumulator with the incoming beat placed in lane r_cnt and every
    // lane above it forced to zero (used for both partial and final words).
    always_comb begin
        w_merged = '0;
        for (int k = 0; k < R; k++) begin
            if (k < int'(r_cnt)) begin
                w_merged[k*IW +: IW] = r_acc[k*IW +: IW];
            end else if (k == int'(r_cnt)) begin
                w_merged[k*IW +: IW] = in_data;
            end
        end
    end

    // Accumulator, lane counter and holding register; a completing accept
    // may coincide with a push so words stream back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
        end else if (w_complete) begin
            r_hold     <= w_merged;
            r_hold_vld <= 1'b1;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= w_merged;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_push) begin
                r_hold_vld <= 1'b0;
            end
        end
    end

    assign in_rdy    = w_in_rdy;
    assign push      = w_push;
    assign push_data = r_hold;
    assign busy      = r_hold_vld | (r_cnt != '0);

endmodule

// File: tb/tb_fifo_push_packer.sv
// Bench for fifo_push_packer (W=32, IW=8): a per-cycle vector table plus
// hand-written backpressure and reset sequences. Expected words are packed
// by the bench from the beats it drives and queued; they are popped and
// compared whenever the DUT pushes.
module tb_fifo_push_packer;

  localparam int W  = 32;
  localparam int IW = 8;
  localparam int R  = W / IW;

  logic          clk;
  logic          rst;
  logic          in_vld;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          in_rdy;
  logic          full_r;
  logic          push;
  logic [W-1:0]  push_data;
  logic          busy;

  fifo_push_packer #(.W(W), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_rdy    (in_rdy),
    .full_r    (full_r),
    .push      (push),
    .push_data (push_data),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_acc;
  int           m_cnt;
  int           n_tests;
  int           n_fail;

  typedef struct {
    logic          vld;
    logic [IW-1:0] data;
    logic          last;
    logic          full;
    logic          e_rdy;
    logic          e_push;
    logic          e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, outputs are
  // checked 1ns later, and the rising edge consumes the inputs.
  task automatic drive_cycle(input logic vld, input logic [IW-1:0] data, input logic last,
                             input logic full, input logic e_rdy, input logic e_push,
                             input logic e_busy, input string name);
    logic [W-1:0] w;
    @(negedge clk);
    in_vld  = vld;
    in_data = data;
    in_last = last;
    full_r  = full;
    #1;
    check({name, ".in_rdy"}, W'(in_rdy), W'(e_rdy));
    check({name, ".push"},   W'(push),   W'(e_push));
    check({name, ".busy"},   W'(busy),   W'(e_busy));
    if (push === 1'b1) begin
      if (exp_q.size() == 0) begin
        check({name, ".unexpected_push"}, push_data, 'x);
      end else begin
        w = exp_q.pop_front();
        check({name, ".push_data"}, push_data, w);
      end
    end
    // bench-side packing of beats the handshake should accept
    if (vld && e_rdy) begin
      m_acc[m_cnt*IW +: IW] = data;
      if (m_cnt == R - 1 || last) begin
        exp_q.push_back(m_acc);
        m_acc = '0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic idle(input logic full, input logic e_rdy, input logic e_push,
                      input logic e_busy, input string name);
    drive_cycle(1'b0, 8'hxx, 1'b0, full, e_rdy, e_push, e_busy, name);
  endtask

  // Pulse reset for one cycle; partial and held data are discarded.
  task automatic pulse_reset(input string name);
    @(negedge clk);
    rst    = 1'b1;
    in_vld = 1'b0;
    full_r = 1'b0;
    #1;
    check({name, ".rst_push"},      W'(push),  32'd0);
    check({name, ".rst_push_data"}, push_data, 32'd0);
    check({name, ".rst_in_rdy"},    W'(in_rdy), 32'd1);
    check({name, ".rst_busy"},      W'(busy),  32'd0);
    exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add(input logic vld, input logic [IW-1:0] data, input logic last,
                     input logic full, input logic e_rdy, input logic e_push, input logic e_busy);
    vec_t v;
    v.vld = vld; v.data = data; v.last = last; v.full = full;
    v.e_rdy = e_rdy; v.e_push = e_push; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_acc   = '0;
    m_cnt   = 0;
    rst     = 1'b1;
    in_vld  = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    full_r  = 1'b0;

    // vld data last full | rdy push busy
    // full word 0x44332211
    add(1, 8'h11, 0, 0, 1, 0, 0);
    add(1, 8'h22, 0, 0, 1, 0, 1);
    add(1, 8'h33, 0, 0, 1, 0, 1);
    add(1, 8'h44, 0, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 0, 0);
    // early close -> 0x0000BBAA
    add(1, 8'hAA, 0, 0, 1, 0, 0);
    add(1, 8'hBB, 1, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 0, 0);
    // single beat -> 0x0000005A
    add(1, 8'h5A, 1, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 0, 0);
    // streaming 8 beats, pushes 4 cycles apart with in_rdy held
    add(1, 8'h01, 0, 0, 1, 0, 0);
    add(1, 8'h02, 0, 0, 1, 0, 1);
    add(1, 8'h03, 0, 0, 1, 0, 1);
    add(1, 8'h04, 0, 0, 1, 0, 1);
    add(1, 8'h05, 0, 0, 1, 1, 1);
    add(1, 8'h06, 0, 0, 1, 0, 1);
    add(1, 8'h07, 0, 0, 1, 0, 1);
    add(1, 8'h08, 0, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 0, 0);
    // in_last on lane R-1: exactly one word
    add(1, 8'hC1, 0, 0, 1, 0, 0);
    add(1, 8'hC2, 0, 0, 1, 0, 1);
    add(1, 8'hC3, 0, 0, 1, 0, 1);
    add(1, 8'hC4, 1, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0, 0);
    // full with empty hold: completing beat still accepted
    add(1, 8'hD1, 1, 1, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 1, 1);
    add(0, 8'h00, 0, 0, 1, 0, 0);

    // reset values while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.push",      W'(push),   32'd0);
    check("reset.push_data", push_data,  32'd0);
    check("reset.in_rdy",    W'(in_rdy), 32'd1);
    check("reset.busy",      W'(busy),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].vld, vecs[i].data, vecs[i].last, vecs[i].full,
                  vecs[i].e_rdy, vecs[i].e_push, vecs[i].e_busy, $sformatf("vec%0d", i));
    end

    // full backpressure: word completes while full, then frozen 10 cycles
    drive_cycle(1, 8'h10, 0, 1, 1, 0, 0, "bp.b0");
    drive_cycle(1, 8'h20, 0, 1, 1, 0, 1, "bp.b1");
    drive_cycle(1, 8'h30, 0, 1, 1, 0, 1, "bp.b2");
    drive_cycle(1, 8'h40, 0, 1, 1, 0, 1, "bp.b3");
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1, 8'h99, 0, 1, 0, 0, 1, $sformatf("bp.frozen%0d", i));
    end
    drive_cycle(1, 8'h50, 0, 0, 1, 1, 1, "bp.release");
    idle(0, 1, 0, 1, "bp.partial");
    drive_cycle(1, 8'h60, 1, 0, 1, 0, 1, "bp.close");
    idle(0, 1, 1, 1, "bp.push2");
    idle(0, 1, 0, 0, "bp.drained");

    // reset mid-word: partial discarded, restart at lane 0
    drive_cycle(1, 8'h11, 0, 0, 1, 0, 0, "rst.b0");
    drive_cycle(1, 8'h22, 0, 0, 1, 0, 1, "rst.b1");
    pulse_reset("rst.mid");
    idle(0, 1, 0, 0, "rst.after");
    drive_cycle(1, 8'h33, 0, 0, 1, 0, 0, "rst.c0");
    drive_cycle(1, 8'h44, 0, 0, 1, 0, 1, "rst.c1");
    drive_cycle(1, 8'h55, 0, 0, 1, 0, 1, "rst.c2");
    drive_cycle(1, 8'h66, 0, 0, 1, 0, 1, "rst.c3");
    idle(0, 1, 1, 1, "rst.push");
    idle(0, 1, 0, 0, "rst.drained");

    // reset with a held word pending behind full
    drive_cycle(1, 8'hE1, 0, 1, 1, 0, 0, "rsth.b0");
    drive_cycle(1, 8'hE2, 0, 1, 1, 0, 1, "rsth.b1");
    drive_cycle(1, 8'hE3, 0, 1, 1, 0, 1, "rsth.b2");
    drive_cycle(1, 8'hE4, 0, 1, 1, 0, 1, "rsth.b3");
    idle(1, 0, 0, 1, "rsth.held");
    pulse_reset("rsth.mid");
    idle(0, 1, 0, 0, "rsth.after0");
    idle(0, 1, 0, 0, "rsth.after1");

    check("final.queue_empty", W'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
